// File: rtl/sparse_chunk_loader.sv
// Write-side producer for the ping-pong sparse chunk store: derives per-byte sparsemaps,
// compacts nonzero bytes into low lanes and tracks ownership of the two chunk buffers.
//
// state | meaning
// ------+--------------------------------------------------------------
// FILL  | accepting beats into buffer sel_q
// WAIT  | buffer sel_q still owned by the read side; input stalled
module sparse_chunk_loader #(
   parameter int BUS_SIZE = 32,
   parameter int MEM_SIZE = 512,
   localparam int WR_DAT_CYC_NUM = MEM_SIZE / BUS_SIZE,
   localparam int CNT_W = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [BUS_SIZE*8-1:0]   in_data_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic                    rd_release_i,
   input  logic                    rd_release_sel_i,
   output logic [BUS_SIZE-1:0]     wr_sparsemap_o,
   output logic [BUS_SIZE*8-1:0]   wr_nonzero_data_o,
   output logic                    wr_valid_o,
   output logic [CNT_W-1:0]        wr_count_o,
   output logic                    wr_sel_o,
   output logic [1:0]              buf_full_o,
   output logic                    chunk_done_o
);

   localparam int IDX_W = $clog2(BUS_SIZE + 1);

   typedef enum logic {FILL = 1'b0, WAIT = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic                    sel_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [1:0]              full_q, full_d;
   logic                    accept, last_beat;
   logic [BUS_SIZE-1:0]     map_c;
   logic [BUS_SIZE*8-1:0]   comp_c;
   logic [IDX_W-1:0]        pos_c [BUS_SIZE];

   // Ready is a pure state decode, gated so the source sees a stall throughout reset.
   assign in_ready_o = rst_i && (state_q == FILL);
   assign accept     = in_valid_i && in_ready_o;
   assign last_beat  = (cnt_q == CNT_W'(WR_DAT_CYC_NUM - 1));

   // pos_c[i] is the output slot a nonzero input lane i lands in.
   always_comb begin
      logic [IDX_W-1:0] run;
      run   = '0;
      map_c = '0;
      for (int i = 0; i < BUS_SIZE; i++) begin
         pos_c[i] = run;
         if (in_data_i[i*8 +: 8] != 8'h00) begin
            map_c[i] = 1'b1;
            run      = run + 1'b1;
         end
      end
   end

   always_comb begin
      comp_c = '0;
      for (int k = 0; k < BUS_SIZE; k++) begin
         for (int i = k; i < BUS_SIZE; i++) begin
            if (map_c[i] && (pos_c[i] == IDX_W'(k)))
               comp_c[k*8 +: 8] = in_data_i[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= FILL;
      else        state_q <= state_d;
   end

   // Set of the completed buffer is applied after release so that set wins on a collision.
   always_comb begin
      full_d  = full_q;
      state_d = state_q;
      if (rd_release_i)
         full_d[rd_release_sel_i] = 1'b0;
      if (accept && last_beat)
         full_d[sel_q] = 1'b1;
      case (state_q)
         FILL: if (accept && last_beat && full_d[~sel_q]) state_d = WAIT;
         WAIT: if (!full_d[sel_q])                        state_d = FILL;
         default:                                         state_d = FILL;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sel_q  <= 1'b0;
         cnt_q  <= '0;
         full_q <= 2'b00;
      end else begin
         full_q <= full_d;
         if (accept) begin
            if (last_beat) begin
               cnt_q <= '0;
               sel_q <= ~sel_q;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_valid_o        <= 1'b0;
         wr_sparsemap_o    <= '0;
         wr_nonzero_data_o <= '0;
         wr_count_o        <= '0;
         wr_sel_o          <= 1'b0;
         chunk_done_o      <= 1'b0;
      end else begin
         wr_valid_o   <= accept;
         chunk_done_o <= accept && last_beat;
         if (accept) begin
            wr_sparsemap_o    <= map_c;
            wr_nonzero_data_o <= comp_c;
            wr_count_o        <= cnt_q;
            wr_sel_o          <= sel_q;
         end
      end
   end

   assign buf_full_o = full_q;

endmodule

// File: doc/sparse_chunk_loader.md
Name: sparse_chunk_loader

Overview:
Write-side producer for the double-buffered sparse chunk store. It accepts dense byte beats over a valid/ready stream and derives a per-byte sparsemap for each beat. Nonzero bytes are compacted into the low lanes, and the block drives the store's write port (sparsemap, nonzero data, valid, beat count, buffer select). It owns ping-pong buffer ownership: it fills one buffer while the read side drains the other, and stalls the input when both buffers are full and unreleased.

Parameters:
BUS_SIZE, 32, bytes per beat; also sparsemap bits per beat.
MEM_SIZE, 512, bytes per chunk buffer; must be a multiple of BUS_SIZE.
WR_DAT_CYC_NUM, MEM_SIZE/BUS_SIZE (derived, localparam), beats per chunk.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
in_data_i  in  BUS_SIZE x 8  dense input bytes, lane 0 = lowest address
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o
rd_release_i  in  1  one-cycle pulse: read side finished a buffer
rd_release_sel_i  in  1  buffer index being released
wr_sparsemap_o  out  BUS_SIZE  bit i = 1 iff in_data_i lane i nonzero
wr_nonzero_data_o  out  BUS_SIZE x 8  compacted nonzero bytes
wr_valid_o  out  1  write strobe to the store
wr_count_o  out  clog2(WR_DAT_CYC_NUM)  beat index within chunk
wr_sel_o  out  1  target buffer of this write
buf_full_o  out  2  per-buffer full flags
chunk_done_o  out  1  pulse coincident with the last beat's wr_valid_o

Behaviour:
- Reset (rst_i low, async): all outputs 0, state FILL, sel_q=0, cnt_q=0, full_q=00. in_ready_o is forced 0 while rst_i is low.
- States:
  - FILL: in_ready_o=1.
  - WAIT: in_ready_o=0.
  - State is registered; in_ready_o decodes from state only (no combinational path from in_valid_i).
- Accept: in FILL with in_valid_i=1. On the next edge:
  - wr_valid_o=1, wr_sparsemap_o=map(in_data_i), wr_nonzero_data_o=compact(in_data_i), wr_count_o=cnt_q, wr_sel_o=sel_q.
  - Latency is exactly 1 cycle, input edge to write strobe.
- No accept: wr_valid_o=0 next cycle. Data, sparsemap, count and sel hold their last values.
- Compaction: output lane k holds the k-th nonzero input byte in ascending lane order. Lanes >= popcount(map) are 0x00. An all-zero beat gives map=0 and all data lanes 0, and is still written and counted.
- Counter:
  - cnt_q increments per accepted beat.
  - On accepting the beat with cnt_q==WR_DAT_CYC_NUM-1: cnt_q wraps to 0, full_q[sel_q] is set, sel_q toggles, and chunk_done_o=1 for one cycle (same cycle as that wr_valid_o).
- Transitions, evaluated each edge with full_q' = next full flags:
  - FILL->WAIT when the last beat is accepted and full_q'[~sel_q]=1.
  - WAIT->FILL when full_q'[sel_q]=0.
- Release: rd_release_i clears full_q[rd_release_sel_i] at the next edge.
  - Releasing a non-full buffer is a no-op.
  - Set and release of the same buffer in the same cycle: set wins.
  - Release of the other buffer in the same cycle as a chunk completion: both take effect, and state stays FILL.
- Release in WAIT of the awaited buffer: in_ready_o=1 one cycle after the release pulse.
- buf_full_o = full_q (registered).
- Reset mid-chunk: the partial chunk is abandoned. cnt_q=0, sel_q=0, full_q=00. The read side must treat both buffers as invalid.
- in_valid_i while in WAIT: ignored, no state change. The upstream source holds its data per valid/ready rules.

Test Plan:
All scenarios use BUS_SIZE=4 and MEM_SIZE=16 (4 beats/chunk).
1. Reset release, then in_data_i lanes{3..0}={00,07,00,05} accepted -> next cycle: wr_valid_o=1, wr_sparsemap_o=4'b0101, wr_nonzero_data_o lanes{3..0}={00,00,07,05}, wr_count_o=0, wr_sel_o=0.
2. Four back-to-back beats {FF,FF,FF,FF}, {00,00,00,00}, {01,00,00,00}, {00,00,02,00} -> wr_count_o=0..3; maps 1111/0000/1000/0010; data lane0 of beats 3 and 4 = 01 and 02; chunk_done_o=1 with count 3; buf_full_o=01; sel_q=1; in_ready_o stays 1.
3. Stream 8 beats with no release -> after beat 8: buf_full_o=11, in_ready_o=0 next cycle. A held in_valid_i produces no wr_valid_o. Pulse rd_release_i with sel 0 -> buf_full_o=10, in_ready_o=1 the cycle after the pulse; next write has wr_sel_o=0 and wr_count_o=0.
4. Beat-4 acceptance of buffer 0 in the same cycle as rd_release_i with sel=1, while buffer 1 is full -> buf_full_o=01, state stays FILL, no stall cycle.
5. rd_release_i with sel=0 while buffer 0 is filling (not full) -> buf_full_o unchanged, counting continues uninterrupted.
6. Drop rst_i asynchronously after 2 beats of a chunk -> outputs 0 immediately. After release, the first write has wr_count_o=0, wr_sel_o=0 and buf_full_o=00.
